// File: rtl/vgg_fp_pkg.sv
// rtl/vgg_fp_pkg.sv - float32 field widths, bias and packed layout shared by the FP units
package vgg_fp_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/int2float_pipe_if.sv
// rtl/int2float_pipe_if.sv - input/output valid-ready streams of the int-to-float converter
interface int2float_pipe_if #(
  parameter int INT_W = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/int2float_pipe_lzc.sv
// rtl/int2float_pipe_lzc.sv - recursive leading-zero counter; count equals W for an all-zero input
module lzc #(
  parameter int W = 8
) (
  input  logic [W-1:0]           i_data,
  output logic [$clog2(W+1)-1:0] o_cnt
);
  localparam int CW = $clog2(W+1);

  generate
    if (W == 1) begin : g_leaf
      assign o_cnt = ~i_data;
    end else begin : g_node
      // Upper half gets floor(W/2) bits so odd widths still split cleanly
      localparam int HW  = W / 2;
      localparam int LW  = W - HW;
      localparam int HCW = $clog2(HW + 1);
      localparam int LCW = $clog2(LW + 1);

      logic [HCW-1:0] w_hi;
      logic [LCW-1:0] w_lo;

      lzc #(.W(HW)) u_hi (.i_data(i_data[W-1 -: HW]), .o_cnt(w_hi));
      lzc #(.W(LW)) u_lo (.i_data(i_data[LW-1:0]),    .o_cnt(w_lo));

      assign o_cnt = (w_hi == HCW'(HW)) ? (CW'(HW) + CW'(w_lo)) : CW'(w_hi);
    end
  endgenerate
endmodule

// File: rtl/int2float_pipe.sv
// rtl/int2float_pipe.sv - 3-stage integer to float32 converter (RNE) with tag sideband and back-pressure
module int2float_pipe
  import vgg_fp_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  int2float_pipe_if.slave bus
);
  localparam int LZ_W = $clog2(INT_W + 1);

  logic             r_v1, r_v2, r_v3;
  logic             w_en1, w_en2, w_en3;
  logic             r_s1, r_z1, r_s2, r_z2;
  logic [INT_W-1:0] r_mag1;
  logic [INT_W-2:0] r_norm2;
  logic [7:0]       r_exp2;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  fp32_t            r_data3;

  // Each stage may load when it is empty or its successor is taking its content
  assign w_en3 = !r_v3 || bus.out_ready;
  assign w_en2 = !r_v2 || w_en3;
  assign w_en1 = !r_v1 || w_en2;
  assign bus.in_ready = w_en1;

  logic             w_s0;
  logic [INT_W-1:0] w_mag0;
  assign w_s0   = (SIGNED != 0) && bus.in_data[INT_W-1];
  assign w_mag0 = w_s0 ? -bus.in_data : bus.in_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1 <= 1'b0; r_s1 <= 1'b0; r_z1 <= 1'b0; r_mag1 <= '0; r_tag1 <= '0;
    end else if (w_en1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1   <= w_s0;
        r_z1   <= (bus.in_data == '0);
        r_mag1 <= w_mag0;
        r_tag1 <= bus.in_tag;
      end
    end
  end

  logic [LZ_W-1:0]  w_lz;
  logic [INT_W-2:0] w_norm1;
  logic [7:0]       w_exp1;

  lzc #(.W(INT_W)) u_lzc (.i_data(r_mag1), .o_cnt(w_lz));

  // The hidden 1 is implied, so only the bits below it are kept
  assign w_norm1 = (INT_W-1)'(r_mag1 << w_lz);
  assign w_exp1  = 8'(FP32_BIAS + INT_W - 1) - 8'(w_lz);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v2 <= 1'b0; r_s2 <= 1'b0; r_z2 <= 1'b0; r_norm2 <= '0; r_exp2 <= '0; r_tag2 <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2    <= r_s1;
        r_z2    <= r_z1;
        r_norm2 <= w_norm1;
        r_exp2  <= w_exp1;
        r_tag2  <= r_tag1;
      end
    end
  end

  logic [FP32_FRAC_W-1:0] w_frac;
  logic                   w_carry;

  generate
    if (INT_W > 24) begin : g_round
      logic [FP32_FRAC_W-1:0] w_frac_raw;
      logic [INT_W-25:0]      w_drop;
      logic                   w_guard, w_sticky, w_inc;
      logic [FP32_FRAC_W:0]   w_sum;

      assign w_frac_raw = r_norm2[INT_W-2 -: FP32_FRAC_W];
      assign w_drop     = r_norm2[INT_W-25:0];
      assign w_guard    = w_drop[INT_W-25];
      // Shifting out the guard bit leaves just the sticky bits
      assign w_sticky   = |(w_drop << 1);
      assign w_inc      = w_guard && (w_sticky || w_frac_raw[0]);
      assign w_sum      = {1'b0, w_frac_raw} + (FP32_FRAC_W+1)'(w_inc);
      assign w_frac     = w_sum[FP32_FRAC_W-1:0];
      assign w_carry    = w_sum[FP32_FRAC_W];
    end else begin : g_exact
      assign w_frac  = FP32_FRAC_W'(r_norm2) << (24 - INT_W);
      assign w_carry = 1'b0;
    end
  endgenerate

  fp32_t w_res;
  assign w_res = r_z2 ? '0 : {r_s2, r_exp2 + 8'(w_carry), w_frac};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v3 <= 1'b0; r_data3 <= '0; r_tag3 <= '0;
    end else if (w_en3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_data3 <= w_res;
        r_tag3  <= r_tag2;
      end
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_data  = r_data3;
  assign bus.out_tag   = r_tag3;
endmodule

// File: tb/tb_int2float_pipe.sv
// tb/tb_int2float_pipe.sv - bench for int2float_pipe at 8-bit unsigned, 16-bit signed and 32-bit unsigned
module tb_int2float_pipe;
  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;
  logic chk_lat = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int2float_pipe_if #(.INT_W(8),  .TAG_W(4)) b8  ();
  int2float_pipe_if #(.INT_W(16), .TAG_W(4)) b16 ();
  int2float_pipe_if #(.INT_W(32), .TAG_W(4)) b32 ();

  int2float_pipe #(.INT_W(8),  .SIGNED(0), .TAG_W(4)) u_dut8  (.clk(clk), .resetn(resetn), .bus(b8));
  int2float_pipe #(.INT_W(16), .SIGNED(1), .TAG_W(4)) u_dut16 (.clk(clk), .resetn(resetn), .bus(b16));
  int2float_pipe #(.INT_W(32), .SIGNED(0), .TAG_W(4)) u_dut32 (.clk(clk), .resetn(resetn), .bus(b32));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  d8;
    logic [31:0] x8;
    logic [15:0] d16;
    logic [31:0] x16;
    logic [31:0] d32;
    logic [31:0] x32;
  } vec_t;

  exp_t q8[$], q16[$], q32[$];
  exp_t e8, e16, e32;
  logic [31:0] cur8, cur16, cur32;
  logic        stall8 = 1'b0;
  logic [31:0] hold_d8;
  logic [3:0]  hold_t8;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // out_ready changes 2 time units after each rising edge
  initial begin
    b8.out_ready = 1'b1; b16.out_ready = 1'b1; b32.out_ready = 1'b1;
    forever begin
      logic r;
      @(posedge clk);
      #2;
      r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      b8.out_ready = r; b16.out_ready = r; b32.out_ready = r;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (b8.in_valid && b8.in_ready) q8.push_back('{cur8, b8.in_tag, cyc});
      if (stall8) begin
        check("hold_valid8", 32'(b8.out_valid), 32'd1);
        check("hold_data8", b8.out_data, hold_d8);
        check("hold_tag8", 32'(b8.out_tag), 32'(hold_t8));
      end
      stall8  = b8.out_valid && !b8.out_ready;
      hold_d8 = b8.out_data;
      hold_t8 = b8.out_tag;
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) check("extra_out8", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check("data8", b8.out_data, e8.data);
          check("tag8", 32'(b8.out_tag), 32'(e8.tag));
          if (chk_lat) check("latency8", 32'(cyc - e8.cyc), 32'd3);
        end
      end
    end else stall8 = 1'b0;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (b16.in_valid && b16.in_ready) q16.push_back('{cur16, b16.in_tag, cyc});
      if (b16.out_valid && b16.out_ready) begin
        if (q16.size() == 0) check("extra_out16", 32'd1, 32'd0);
        else begin
          e16 = q16.pop_front();
          check("data16", b16.out_data, e16.data);
          check("tag16", 32'(b16.out_tag), 32'(e16.tag));
          if (chk_lat) check("latency16", 32'(cyc - e16.cyc), 32'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (b32.in_valid && b32.in_ready) q32.push_back('{cur32, b32.in_tag, cyc});
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) check("extra_out32", 32'd1, 32'd0);
        else begin
          e32 = q32.pop_front();
          check("data32", b32.out_data, e32.data);
          check("tag32", 32'(b32.out_tag), 32'(e32.tag));
          if (chk_lat) check("latency32", 32'(cyc - e32.cyc), 32'd3);
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((q8.size() + q16.size() + q32.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(q8.size() + q16.size() + q32.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic [3:0] t, input logic [31:0] x);
    int   n = 0;
    logic acc = 1'b0;
    b8.in_valid = 1'b1; b8.in_data = d; b8.in_tag = t; cur8 = x;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = b8.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    b8.in_valid = 1'b0;
    if (!acc) check("send_timeout8", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[5];
    logic [7:0]  bpd[10];
    logic [31:0] bpx[10];

    vecs[0] = '{8'd0,   32'h0000_0000, 16'hFFFF, 32'hBF80_0000, 32'd16777217, 32'h4B80_0000};
    vecs[1] = '{8'd1,   32'h3F80_0000, 16'h8000, 32'hC700_0000, 32'd16777219, 32'h4B80_0002};
    vecs[2] = '{8'd255, 32'h437F_0000, 16'h7FFF, 32'h46FF_FE00, 32'hFFFF_FFFF, 32'h4F80_0000};
    vecs[3] = '{8'd128, 32'h4300_0000, 16'h0000, 32'h0000_0000, 32'h8000_0000, 32'h4F00_0000};
    vecs[4] = '{8'd2,   32'h4000_0000, 16'hFF80, 32'hC300_0000, 32'd33554435, 32'h4C00_0001};

    bpd = '{8'd3, 8'd5, 8'd7, 8'd10, 8'd16, 8'd100, 8'd200, 8'd64, 8'd127, 8'd254};
    bpx = '{32'h4040_0000, 32'h40A0_0000, 32'h40E0_0000, 32'h4120_0000, 32'h4180_0000,
            32'h42C8_0000, 32'h4348_0000, 32'h4280_0000, 32'h42FE_0000, 32'h437E_0000};

    resetn = 1'b0;
    b8.in_valid = 1'b0;  b8.in_data = '0;  b8.in_tag = '0;  cur8 = '0;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_tag = '0; cur16 = '0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_tag = '0; cur32 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid8", 32'(b8.out_valid), 32'd0);
    check("rst_data8", b8.out_data, 32'd0);
    check("rst_tag8", 32'(b8.out_tag), 32'd0);
    check("rst_valid32", 32'(b32.out_valid), 32'd0);
    check("rst_data32", b32.out_data, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready8", 32'(b8.in_ready), 32'd1);
    check("rst_in_ready16", 32'(b16.in_ready), 32'd1);
    check("rst_in_ready32", 32'(b32.in_ready), 32'd1);

    // Back-to-back conversion table on all three widths
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = 1'b1;  b8.in_data = vecs[i].d8;   b8.in_tag = 4'(i);  cur8 = vecs[i].x8;
      b16.in_valid = 1'b1; b16.in_data = vecs[i].d16; b16.in_tag = 4'(i); cur16 = vecs[i].x16;
      b32.in_valid = 1'b1; b32.in_data = vecs[i].d32; b32.in_tag = 4'(i); cur32 = vecs[i].x32;
      @(posedge clk);
      #1;
    end
    b8.in_valid = 1'b0; b16.in_valid = 1'b0; b32.in_valid = 1'b0;
    wait_drain();

    // Random back-pressure with tagged samples
    chk_lat = 1'b0;
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) send8(bpd[k], 4'(k + 3), bpx[k]);
    rdy_mode = 0;
    wait_drain();

    // Fill with out_ready low: three accepted, then in_ready drops
    rdy_mode = 2;
    b8.in_valid = 1'b1; b8.in_data = 8'd1; b8.in_tag = 4'd1; cur8 = 32'h3F80_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fill_in_ready", 32'(b8.in_ready), (k < 3) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      if (k == 0) begin b8.in_data = 8'd2; b8.in_tag = 4'd2; cur8 = 32'h4000_0000; end
      if (k == 1) begin b8.in_data = 8'd3; b8.in_tag = 4'd3; cur8 = 32'h4040_0000; end
      if (k == 2) begin b8.in_data = 8'd4; b8.in_tag = 4'd4; cur8 = 32'h4080_0000; end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(b8.in_ready), 32'd0);
      check("stall_out_data", b8.out_data, 32'h3F80_0000);
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    @(negedge clk);
    check("recover_in_ready", 32'(b8.in_ready), 32'd1);
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    wait_drain();

    // Reset with three samples in flight
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) begin
      b8.in_valid = 1'b1; b8.in_data = 8'(k + 1); b8.in_tag = 4'(k + 10); cur8 = 32'h0;
      @(posedge clk);
      #1;
    end
    b8.in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_valid", 32'(b8.out_valid), 32'd0);
    check("midrst_data", b8.out_data, 32'd0);
    q8.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rdy_mode = 0;
    chk_lat = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 32'(b8.in_ready), 32'd1);
    @(posedge clk);
    #1;
    b8.in_valid = 1'b1; b8.in_data = 8'd5; b8.in_tag = 4'd7; cur8 = 32'h40A0_0000;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    wait_drain();
    check("final_out_valid", 32'(b8.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
